// File: rtl/isa_pack_pkg.sv
// Shared widths, address-decode helpers and the queued line record for the ISA width packer.
package isa_pack_pkg;

   localparam int DEF_IN_W   = 64;
   localparam int DEF_RATIO  = 2;
   localparam int DEF_ADDR_W = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   function automatic int lane_bytes(input int in_w);
      return in_w / 8;
   endfunction

   // Byte-offset bits inside one input word.
   function automatic int lb_of(input int in_w);
      return clog2(lane_bytes(in_w));
   endfunction

   // Byte-offset bits inside one packed line.
   function automatic int line_lb_of(input int in_w, input int ratio);
      return clog2(lane_bytes(in_w) * ratio);
   endfunction

   localparam int LANE_W  = DEF_IN_W;
   localparam int LB      = lb_of(DEF_IN_W);
   localparam int LINE_LB = line_lb_of(DEF_IN_W, DEF_RATIO);

   typedef struct packed {
      logic [DEF_ADDR_W-1:0]           addr;
      logic [DEF_RATIO-1:0]            mask;
      logic [DEF_IN_W*DEF_RATIO-1:0]   data;
   } line_entry_t;

endpackage

// File: rtl/isa_line_fifo.sv
// First-word-fall-through line queue: head is valid the cycle after the first push.
// Pushes into a full queue and pops from an empty one are ignored; push and pop may coincide.
module isa_line_fifo
   import isa_pack_pkg::*;
#(
   parameter int  DEPTH   = 4,
   parameter type entry_t = line_entry_t
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  entry_t               push_entry,
   input  logic                 pop,
   output entry_t               head,
   output logic                 full,
   output logic                 empty,
   output logic [clog2(DEPTH):0] count
);

   localparam int AW = clog2(DEPTH);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers wrap naturally; the extra count bit separates full from empty.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (do_push && !do_pop) begin
            count <= count + 1'b1;
         end else if (do_pop && !do_push) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/isa_width_packer.sv
// Address-directed packer merging IN_W-bit ISA writes into RATIO-lane instruction RAM lines.
// A pushed line is visible the next cycle; input stalls while flush is held or the line queue is full.
module isa_width_packer
   import isa_pack_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int RATIO      = DEF_RATIO,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  isa_valid_i,
   output logic                  isa_ready_o,
   input  logic [IN_W-1:0]       isa_data_i,
   input  logic [ADDR_W-1:0]     isa_addr_i,
   input  logic                  flush_i,
   output logic                  line_valid_o,
   input  logic                  line_ready_i,
   output logic [IN_W*RATIO-1:0] line_data_o,
   output logic [ADDR_W-1:0]     line_addr_o,
   output logic [RATIO-1:0]      line_mask_o,
   output logic                  err_misalign_o
);

   localparam int OUT_W = IN_W * RATIO;
   localparam int WLB   = lb_of(IN_W);
   localparam int LLB   = line_lb_of(IN_W, RATIO);
   localparam int RB    = clog2(RATIO);
   localparam int CW    = clog2(FIFO_DEPTH) + 1;
   localparam int TW    = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

   localparam logic [ADDR_W-1:0] WORD_OFS = ADDR_W'((1 << WLB) - 1);
   localparam logic [ADDR_W-1:0] LINE_OFS = ADDR_W'((1 << LLB) - 1);
   localparam logic [TW-1:0]     T_LAST   = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [TW-1:0]     T_MAX    = TW'(TIMEOUT);

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [RATIO-1:0]  mask;
      logic [OUT_W-1:0]  data;
   } entry_t;

   // Accumulator: acc_part distinguishes PARTIAL from EMPTY.
   logic              acc_part;
   logic [ADDR_W-1:0] acc_base;
   logic [RATIO-1:0]  acc_mask;
   logic [OUT_W-1:0]  acc_data;
   logic [TW-1:0]     timer;
   logic              err;

   logic              nxt_part;
   logic [ADDR_W-1:0] nxt_base;
   logic [RATIO-1:0]  nxt_mask;
   logic [OUT_W-1:0]  nxt_data;

   logic [RB-1:0]     lane;
   logic [ADDR_W-1:0] base;
   logic              accept;
   logic              collide;
   logic              timeout_hit;
   logic              push;
   entry_t            push_entry;
   logic              pop;
   entry_t            head;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign lane        = isa_addr_i[WLB +: RB];
   assign base        = isa_addr_i & ~LINE_OFS;
   assign accept      = isa_valid_i & isa_ready_o;
   assign collide     = acc_part & ((base != acc_base) | acc_mask[lane]);
   assign timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);

   // A pop in the same cycle does not open a slot for an incoming word.
   assign isa_ready_o = ~rst_i & ~flush_i & (fifo_count < CW'(FIFO_DEPTH));

   always_comb begin
      push            = 1'b0;
      push_entry.addr = acc_base;
      push_entry.mask = acc_mask;
      push_entry.data = acc_data;
      nxt_part        = acc_part;
      nxt_base        = acc_base;
      nxt_mask        = acc_mask;
      nxt_data        = acc_data;

      if (accept) begin
         // A collision evicts the old line untouched and restarts from this word alone.
         if (collide) begin
            push = 1'b1;
         end
         if (collide || !acc_part) begin
            nxt_mask = '0;
            nxt_data = '0;
         end
         nxt_base                      = base;
         nxt_mask[lane]                = 1'b1;
         nxt_data[lane*IN_W +: IN_W]   = isa_data_i;
         nxt_part                      = 1'b1;
         if (!collide && (&nxt_mask)) begin
            push            = 1'b1;
            push_entry.addr = base;
            push_entry.mask = nxt_mask;
            push_entry.data = nxt_data;
            nxt_part        = 1'b0;
            nxt_mask        = '0;
            nxt_data        = '0;
         end
      end else if (acc_part && !fifo_full && (flush_i || timeout_hit)) begin
         push     = 1'b1;
         nxt_part = 1'b0;
         nxt_mask = '0;
         nxt_data = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_part <= 1'b0;
         acc_base <= '0;
         acc_mask <= '0;
         acc_data <= '0;
         timer    <= '0;
         err      <= 1'b0;
      end else begin
         acc_part <= nxt_part;
         acc_base <= nxt_base;
         acc_mask <= nxt_mask;
         acc_data <= nxt_data;
         // Timer holds at its last value while a timeout push waits on a full queue.
         if (accept || push || !acc_part) begin
            timer <= '0;
         end else if (!timeout_hit && timer != T_MAX) begin
            timer <= timer + 1'b1;
         end
         if (accept && ((isa_addr_i & WORD_OFS) != '0)) begin
            err <= 1'b1;
         end
      end
   end

   isa_line_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk        (clk_i),
      .rst        (rst_i),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head       (head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count)
   );

   assign line_valid_o   = ~rst_i & ~fifo_empty;
   assign pop            = line_valid_o & line_ready_i;
   assign line_addr_o    = line_valid_o ? head.addr : '0;
   assign line_mask_o    = line_valid_o ? head.mask : '0;
   assign line_data_o    = line_valid_o ? head.data : '0;
   assign err_misalign_o = ~rst_i & err;

endmodule
